// File: rtl/dsd_modulator.sv
// Second-order 1-bit delta-sigma modulator: signed PCM in, DSD bitstream out.
// Integrators saturate at the ACC_W range; a sticky flag records any clamp.
module dsd_modulator #(
    parameter int DIV   = 4,
    parameter int PCM_W = 16,
    parameter int ACC_W = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [PCM_W-1:0] pcm,
    input  logic             en,
    input  logic             clr_clip,
    output logic             dsd,
    output logic             tick,
    output logic             clip
);

    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int SUM_W = ACC_W + 2;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
    localparam logic signed [SUM_W-1:0] FS      = SUM_W'(1) << (PCM_W - 1);
    localparam logic signed [SUM_W-1:0] ACC_MAX = (SUM_W'(1) << (ACC_W - 1)) - SUM_W'(1);
    localparam logic signed [SUM_W-1:0] ACC_MIN = -(SUM_W'(1) << (ACC_W - 1));

    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic signed [ACC_W-1:0] i1_q, i1_d, i2_q, i2_d;
    logic signed [ACC_W-1:0] i1_sat, i2_sat;
    logic signed [SUM_W-1:0] x, fb, sum1, sum2;
    logic                    dsd_q, dsd_d, tick_q, clip_q, clip_d;
    logic                    tick_cycle, clamp1, clamp2, clip_set;

    always_comb begin
        tick_cycle = (cnt_q == CNT_LAST);
        cnt_d      = tick_cycle ? '0 : cnt_q + CNT_W'(1);

        x  = {{(SUM_W - PCM_W){pcm[PCM_W-1]}}, pcm};
        fb = dsd_q ? FS : -FS;

        sum1   = SUM_W'(i1_q) + x - fb;
        clamp1 = (sum1 > ACC_MAX) || (sum1 < ACC_MIN);
        if (sum1 > ACC_MAX) begin
            i1_sat = ACC_MAX[ACC_W-1:0];
        end else if (sum1 < ACC_MIN) begin
            i1_sat = ACC_MIN[ACC_W-1:0];
        end else begin
            i1_sat = sum1[ACC_W-1:0];
        end

        // Second stage integrates the already-clamped first-stage result.
        sum2   = SUM_W'(i2_q) + SUM_W'(i1_sat) - fb;
        clamp2 = (sum2 > ACC_MAX) || (sum2 < ACC_MIN);
        if (sum2 > ACC_MAX) begin
            i2_sat = ACC_MAX[ACC_W-1:0];
        end else if (sum2 < ACC_MIN) begin
            i2_sat = ACC_MIN[ACC_W-1:0];
        end else begin
            i2_sat = sum2[ACC_W-1:0];
        end

        i1_d     = i1_q;
        i2_d     = i2_q;
        dsd_d    = dsd_q;
        clip_set = 1'b0;
        if (tick_cycle) begin
            if (en) begin
                i1_d     = i1_sat;
                i2_d     = i2_sat;
                dsd_d    = ~i2_sat[ACC_W-1];
                clip_set = clamp1 | clamp2;
            end else begin
                i1_d  = '0;
                i2_d  = '0;
                dsd_d = ~dsd_q;
            end
        end

        clip_d = clip_set | (clip_q & ~clr_clip);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            i1_q   <= '0;
            i2_q   <= '0;
            dsd_q  <= 1'b0;
            tick_q <= 1'b0;
            clip_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            i1_q   <= i1_d;
            i2_q   <= i2_d;
            dsd_q  <= dsd_d;
            tick_q <= tick_cycle;
            clip_q <= clip_d;
        end
    end

    assign dsd  = dsd_q;
    assign tick = tick_q;
    assign clip = clip_q;

endmodule
